// File: rtl/el2_trace_packer.sv
// Retired-instruction trace packer: captures core trace packets into a small FIFO
// and serializes each one as header/address/insn[/tval] words on a valid/ready stream.
module el2_trace_packer #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          trace_en,
  input  logic          trace_rv_i_valid_ip,
  input  logic [31:0]   trace_rv_i_insn_ip,
  input  logic [31:0]   trace_rv_i_address_ip,
  input  logic          trace_rv_i_exception_ip,
  input  logic [4:0]    trace_rv_i_ecause_ip,
  input  logic          trace_rv_i_interrupt_ip,
  input  logic [31:0]   trace_rv_i_tval_ip,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic [CW:0]   fifo_level,
  output logic [15:0]   drop_cnt,
  output logic [2:0]    dbg_state
);

  // Stream handshake: a word transfers on a rising clk edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, out_data
  // and out_last hold their value and out_valid never drops until the transfer.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ADDR = 3'd2,
    S_INSN = 3'd3,
    S_TVAL = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
    logic [31:0] tval;
    logic        exc;
    logic [4:0]  ecause;
    logic        intr;
    logic [7:0]  seq;
    logic        drop;
  } entry_t;

  localparam logic [CW:0] FULL_LVL = (CW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry;
  entry_t        head;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW:0]   level_q, level_d;
  logic [7:0]    seq_q, seq_d;
  logic          drop_pending_q, drop_pending_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          offer;
  logic          push;
  logic          pop;
  logic          drop;
  logic          hs;
  logic          head_trap;
  logic          last_word;
  logic [31:0]   hdr_word;

  assign head      = mem_q[rd_ptr_q];
  assign head_trap = head.exc | head.intr;
  assign hs        = out_valid & out_ready;
  assign last_word = ((state_q == S_INSN) & ~head_trap) | (state_q == S_TVAL);
  assign hdr_word  = {4'hA, head.seq, head.drop, head.exc, head.intr, head.ecause, 12'h000};

  // A full FIFO still accepts when the head's final word leaves this same cycle.
  always_comb begin
    offer = trace_rv_i_valid_ip & trace_en;
    pop   = hs & last_word;
    push  = offer & ((level_q < FULL_LVL) | pop);
    drop  = offer & ~push;
  end

  always_comb begin
    wr_entry        = '0;
    wr_entry.addr   = trace_rv_i_address_ip;
    wr_entry.insn   = trace_rv_i_insn_ip;
    wr_entry.tval   = trace_rv_i_tval_ip;
    wr_entry.exc    = trace_rv_i_exception_ip;
    wr_entry.ecause = trace_rv_i_ecause_ip;
    wr_entry.intr   = trace_rv_i_interrupt_ip;
    wr_entry.seq    = seq_q;
    wr_entry.drop   = drop_pending_q;
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    seq_d          = seq_q;
    drop_pending_d = drop_pending_q;
    drop_cnt_d     = drop_cnt_q;
    if (push) begin
      wr_ptr_d       = wr_ptr_q + CW'(1);
      seq_d          = seq_q + 8'd1;
      drop_pending_d = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (CW+1)'(1);
      2'b01:   level_d = level_q - (CW+1)'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      drop_pending_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Leaving IDLE on the push edge gives a one-cycle capture-to-valid latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) || push) state_d = S_HDR;
      end
      S_HDR: begin
        if (hs) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (hs) state_d = S_INSN;
      end
      S_INSN: begin
        if (hs) begin
          if (head_trap)             state_d = S_TVAL;
          else if (level_d != '0)    state_d = S_HDR;
          else                       state_d = S_IDLE;
        end
      end
      S_TVAL: begin
        if (hs) begin
          if (level_d != '0) state_d = S_HDR;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q != S_IDLE);
    out_last  = last_word;
    out_data  = 32'h0;
    case (state_q)
      S_HDR:   out_data = hdr_word;
      S_ADDR:  out_data = head.addr;
      S_INSN:  out_data = head.insn;
      S_TVAL:  out_data = head.tval;
      default: out_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      seq_q          <= 8'h00;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= 16'h0000;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      seq_q          <= seq_d;
      drop_pending_q <= drop_pending_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Payload storage carries no reset; entries are only read once pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign fifo_level = level_q;
  assign drop_cnt   = drop_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/el2_trace_packer.md
Name: el2_trace_packer

Overview:
- Consumes the per-cycle retired-instruction trace packet (el2_trace_pkt_t fields) that the core emits.
- Buffers accepted packets in a small FIFO.
- Serializes each packet into a 32-bit word stream with a valid/ready handshake for a downstream trace sink or debug-bus capture buffer.
- Counts and flags packets dropped under backpressure.

Parameters:
- DEPTH, 8, FIFO depth in packets; power of two, 2..64.
- CW, 3, pointer width, $clog2(DEPTH).

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- trace_en  in  1  capture enable; sampled every cycle
- trace_rv_i_valid_ip  in  1  retire valid
- trace_rv_i_insn_ip  in  32  instruction
- trace_rv_i_address_ip  in  32  PC
- trace_rv_i_exception_ip  in  1  exception flag
- trace_rv_i_ecause_ip  in  5  exception cause
- trace_rv_i_interrupt_ip  in  1  interrupt flag
- trace_rv_i_tval_ip  in  32  trap value
- out_valid  out  1  word available
- out_ready  in  1  sink accepts word
- out_data  out  32  stream word
- out_last  out  1  final word of the current packet
- fifo_level  out  CW+1  packets held, including the one being serialized
- drop_cnt  out  16  dropped packets, saturating

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - out_valid=0, out_data=0, out_last=0, fifo_level=0, drop_cnt=0.
  - Seq counter=0, drop_pending=0, FSM=IDLE, pointers=0.
- Capture:
  - A packet is offered when trace_rv_i_valid_ip & trace_en.
  - It is accepted if fifo_level<DEPTH, or if this cycle completes the last-word handshake of the head packet (simultaneous pop frees the slot; level unchanged).
  - Stored entry: addr, insn, tval, exc, ecause, int, seq[7:0], drop flag = drop_pending.
  - On accept: seq += 1, wrapping at 8 bits. drop_pending is cleared.
- Drop:
  - An offered but not accepted packet increments drop_cnt, saturating at 16'hFFFF, and sets drop_pending.
  - Seq is not incremented on a drop.
- Serializer FSM, states IDLE, HDR, ADDR, INSN, TVAL:
  - IDLE -> HDR when fifo_level!=0, including a packet written this cycle one cycle later. Out_valid therefore rises the cycle after the accept edge (1-cycle latency).
  - HDR -> ADDR -> INSN on out_valid&out_ready.
  - INSN -> TVAL if head exc|int, else pop.
  - TVAL -> pop.
  - Pop: -> HDR if another packet remains after the pop, else -> IDLE. No bubble between back-to-back packets.
- Output rules:
  - out_valid=1 in every state except IDLE.
  - out_data and out_last are held stable while out_valid&!out_ready.
  - out_last=1 in INSN when !(exc|int), and in TVAL.
  - out_data is 0 in IDLE.
- Header word layout:
  - [31:28]=4'hA
  - [27:20]=seq
  - [19]=drop flag
  - [18]=exc
  - [17]=int
  - [16:12]=ecause
  - [11:0]=0
- Word order: header, address, insn, then tval only for trap packets.
- trace_en deassert stops capture only; queued packets drain normally. drop_cnt and seq are unchanged while disabled.
- Pointer wrap at DEPTH is naturally modulo. fifo_level is updated the same cycle as the push/pop edge.
- Reset mid-packet abandons the in-flight packet. No partial stream resumes after reset.

Test Plan:
- Single non-trap packet (addr 0x8000_0000, insn 0x0000_0013), out_ready=1 -> words 0xA000_0000, 0x8000_0000, 0x0000_0013; out_last on the 3rd; out_valid first high 1 cycle after capture.
- Trap packet (exc=1, ecause=2, tval=0xDEAD_BEEF) as the 2nd packet -> header 0xA014_2000, then addr, insn, 0xDEAD_BEEF with out_last=1.
- out_ready=0 while 10 packets are offered back-to-back, DEPTH=8 -> fifo_level=8, drop_cnt=2. Releasing ready shows the 9th accepted packet with header bit19=1 and seq continuing without gaps.
- Full FIFO, offer a packet in the same cycle as the head's last-word handshake -> packet accepted, drop_cnt unchanged, level stays 8.
- Random out_ready toggling over 300 packets -> out_data stable while stalled; seq wraps 0xFF->0x00; scoreboard matches all words.
- Assert rst_l mid-ADDR word -> all outputs 0 immediately; after release, the first header has seq 0.
